// File: rtl/pattern_generator_pkg.sv
// Shared types for the pattern generator: pattern mode encoding.
package pattern_gen_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    TABLE  = 2'd0,
    RAMP   = 2'd1,
    CONST  = 2'd2,
    SQUARE = 2'd3
  } mode_e;

endpackage

// File: rtl/pattern_generator_if.sv
// AXI-Stream style sample channel between the pattern generator and the DAC driver.
interface pattern_generator_if #(
  parameter int unsigned DATA_W = 16
);

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/pattern_generator_table.sv
// Runtime-writable sample table: synchronous write, two asynchronous read ports
// (indexed read plus a fixed mem[1] tap for the square pattern).
module pattern_table #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [DATA_W-1:0]          rd_data,
  output logic [DATA_W-1:0]          rd1_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  // Table write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data  = mem[rd_addr];
  assign rd1_data = mem[AW'(1)];

endmodule

// File: rtl/pattern_generator.sv
// Pattern generator: table / ramp / constant / square sample source with a
// registered valid/ready output stage.
// Build option: define PATTERN_GEN_CNT_EN to add the 32-bit accepted-beat counter output beat_cnt.
module pattern_generator
  import pattern_gen_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  mode_e                    mode,
  input  logic [DATA_W-1:0]        step,
  input  logic [$clog2(DEPTH)-1:0] tbl_last,
  input  logic                     tbl_wr_en,
  input  logic [$clog2(DEPTH)-1:0] tbl_wr_addr,
  input  logic [DATA_W-1:0]        tbl_wr_data,
  pattern_generator_if.master      m_axis
`ifdef PATTERN_GEN_CNT_EN
  ,
  output logic [31:0]              beat_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              last_q;
  logic [AW-1:0]     idx;
  logic [DATA_W-1:0] acc;
  mode_e             mode_q;

  logic              advance;
  logic              mode_chg;
  logic [AW-1:0]     idx_base;
  logic [AW-1:0]     idx_tbl;
  logic [AW-1:0]     idx_nxt;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] acc_base;
  logic [DATA_W-1:0] acc_nxt;
  logic [DATA_W-1:0] ramp_sum;
  logic              ramp_carry;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] rd1_data;
  logic [DATA_W-1:0] data_nxt;
  logic              last_nxt;

  pattern_table #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_table (
    .clk      (clk),
    .wr_en    (tbl_wr_en),
    .wr_addr  (tbl_wr_addr),
    .wr_data  (tbl_wr_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd1_data (rd1_data)
  );

  // Load a new beat when the output slot is empty or being drained this cycle.
  assign advance  = enable && (!valid_q || m_axis.ready);
  // A mode change restarts the pattern from its first beat.
  assign mode_chg = (mode != mode_q);
  assign idx_base = mode_chg ? '0 : idx;
  assign acc_base = mode_chg ? '0 : acc;
  // An index left beyond a lowered tbl_last wraps back to entry 0.
  assign idx_tbl  = (idx_base > tbl_last) ? '0 : idx_base;
  assign rd_addr  = (mode == TABLE) ? idx_tbl : '0;
  assign {ramp_carry, ramp_sum} = {1'b0, acc_base} + {1'b0, step};

  // Next-beat mux: data/last plus the pattern state that follows it.
  always_comb begin
    idx_nxt  = idx_base;
    acc_nxt  = acc_base;
    data_nxt = rd_data;
    last_nxt = 1'b0;
    case (mode)
      TABLE: begin
        last_nxt = (idx_tbl == tbl_last);
        idx_nxt  = (idx_tbl == tbl_last) ? '0 : idx_tbl + AW'(1);
      end
      RAMP: begin
        data_nxt = acc_base;
        acc_nxt  = ramp_sum;
        last_nxt = ramp_carry;
      end
      SQUARE: begin
        data_nxt = idx_base[0] ? rd1_data : rd_data;
        last_nxt = idx_base[0];
        idx_nxt  = AW'(~idx_base[0]);
      end
      default: begin
        data_nxt = rd_data;
        last_nxt = 1'b0;
      end
    endcase
  end

  // Output register and pattern state; a held beat never changes until accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      idx     <= '0;
      acc     <= '0;
      mode_q  <= TABLE;
    end else if (advance) begin
      valid_q <= 1'b1;
      data_q  <= data_nxt;
      last_q  <= last_nxt;
      idx     <= idx_nxt;
      acc     <= acc_nxt;
      mode_q  <= mode;
    end else if (m_axis.ready) begin
      valid_q <= 1'b0;
    end
  end

  assign m_axis.valid = valid_q;
  assign m_axis.data  = data_q;
  assign m_axis.last  = last_q;

`ifdef PATTERN_GEN_CNT_EN
  // Count every completed handshake; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (valid_q && m_axis.ready) begin
      beat_cnt <= beat_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pattern_generator.sv
// Self-checking bench for pattern_generator: directed vector table, hand-written
// corner sequences, then randomized traffic against a behavioural model.
module tb_pattern_generator;
  import pattern_gen_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        en;
  mode_e       md;
  logic [15:0] step;
  logic [3:0]  tbl_last;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
`ifdef PATTERN_GEN_CNT_EN
  logic [31:0] beat_cnt;
`endif

  pattern_generator_if #(.DATA_W(16)) axis ();

  pattern_generator #(.DATA_W(16), .DEPTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (en),
    .mode        (md),
    .step        (step),
    .tbl_last    (tbl_last),
    .tbl_wr_en   (wr_en),
    .tbl_wr_addr (wr_addr),
    .tbl_wr_data (wr_data),
    .m_axis      (axis)
`ifdef PATTERN_GEN_CNT_EN
    ,
    .beat_cnt    (beat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        en;
    logic        rdy;
    mode_e       md;
    logic        ev;
    logic [15:0] ed;
    logic        el;
  } vec_t;

  vec_t vecs[19];

  // Behavioural model state: the visible beat plus pattern position in plain integers.
  int          m_valid, m_data, m_last, m_pos, m_mode;
  longint      m_acc;
  int unsigned m_cnt;
  int          m_tbl[16];

  function automatic vec_t mk(logic e, logic r, mode_e m, logic v, logic [15:0] d, logic l);
    vec_t x;
    x.en = e; x.rdy = r; x.md = m; x.ev = v; x.ed = d; x.el = l;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string name, input logic v, input logic [15:0] d, input logic l);
    chk({name, ".valid"}, 32'(axis.valid), 32'(v));
    chk({name, ".data"},  32'(axis.data),  32'(d));
    chk({name, ".last"},  32'(axis.last),  32'(l));
  endtask

  task automatic write_word(input logic [3:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Reference: one clock of the generator as seen from outside, using the current inputs.
  task automatic model_step();
    int tl;
    tl = int'(tbl_last);
    if (!rst_n) begin
      m_valid = 0; m_data = 0; m_last = 0; m_pos = 0; m_acc = 0; m_mode = 0; m_cnt = 0;
    end else begin
      if (m_valid == 1 && axis.ready) m_cnt++;
      if (en && (m_valid == 0 || axis.ready)) begin
        if (int'(md) != m_mode) begin
          m_pos = 0;
          m_acc = 0;
        end
        m_mode = int'(md);
        case (m_mode)
          0: begin
            if (m_pos > tl) m_pos = 0;
            m_data = m_tbl[m_pos];
            m_last = (m_pos == tl) ? 1 : 0;
            m_pos  = (m_pos == tl) ? 0 : m_pos + 1;
          end
          1: begin
            m_data = int'(m_acc);
            m_acc  = m_acc + longint'(step);
            m_last = (m_acc >= 65536) ? 1 : 0;
            m_acc  = m_acc % 65536;
          end
          2: begin
            m_data = m_tbl[0];
            m_last = 0;
          end
          default: begin
            m_data = m_tbl[m_pos % 2];
            m_last = (m_pos % 2 == 1) ? 1 : 0;
            m_pos  = (m_pos + 1) % 2;
          end
        endcase
        m_valid = 1;
      end else if (m_valid == 1 && axis.ready) begin
        m_valid = 0;
      end
    end
    // Table write lands after the read: a same-cycle read sees the old word.
    if (wr_en) m_tbl[wr_addr] = int'(wr_data);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; md = TABLE; step = 16'h4000; tbl_last = 4'd3;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; axis.ready = 1'b0;

    // Reset state
    tick(); tick();
    chk_beat("reset", 1'b0, 16'h0000, 1'b0);
`ifdef PATTERN_GEN_CNT_EN
    chk("reset.cnt", beat_cnt, 32'd0);
`endif
    rst_n = 1'b1;

    // Table contents
    write_word(4'd0, 16'hCAFE);
    write_word(4'd1, 16'hC0DE);
    write_word(4'd2, 16'hBEEF);
    write_word(4'd3, 16'hB0BA);
    for (int i = 4; i < 16; i++) write_word(4'(i), 16'h1000 + 16'(i));
    chk("idle.valid", 32'(axis.valid), 32'd0);

    // TABLE playback, stall, idle, RAMP, back to TABLE
    vecs[0]  = mk(1'b1, 1'b1, TABLE, 1'b1, 16'hCAFE, 1'b0);
    vecs[1]  = mk(1'b1, 1'b1, TABLE, 1'b1, 16'hC0DE, 1'b0);
    vecs[2]  = mk(1'b1, 1'b1, TABLE, 1'b1, 16'hBEEF, 1'b0);
    vecs[3]  = mk(1'b1, 1'b1, TABLE, 1'b1, 16'hB0BA, 1'b1);
    vecs[4]  = mk(1'b1, 1'b1, TABLE, 1'b1, 16'hCAFE, 1'b0);
    vecs[5]  = mk(1'b1, 1'b0, TABLE, 1'b1, 16'hCAFE, 1'b0);
    vecs[6]  = mk(1'b1, 1'b0, TABLE, 1'b1, 16'hCAFE, 1'b0);
    vecs[7]  = mk(1'b1, 1'b0, TABLE, 1'b1, 16'hCAFE, 1'b0);
    vecs[8]  = mk(1'b1, 1'b1, TABLE, 1'b1, 16'hC0DE, 1'b0);
    vecs[9]  = mk(1'b1, 1'b1, TABLE, 1'b1, 16'hBEEF, 1'b0);
    vecs[10] = mk(1'b1, 1'b1, TABLE, 1'b1, 16'hB0BA, 1'b1);
    vecs[11] = mk(1'b1, 1'b1, TABLE, 1'b1, 16'hCAFE, 1'b0);
    vecs[12] = mk(1'b0, 1'b1, TABLE, 1'b0, 16'hCAFE, 1'b0);
    vecs[13] = mk(1'b1, 1'b1, RAMP,  1'b1, 16'h0000, 1'b0);
    vecs[14] = mk(1'b1, 1'b1, RAMP,  1'b1, 16'h4000, 1'b0);
    vecs[15] = mk(1'b1, 1'b1, RAMP,  1'b1, 16'h8000, 1'b0);
    vecs[16] = mk(1'b1, 1'b1, RAMP,  1'b1, 16'hC000, 1'b1);
    vecs[17] = mk(1'b1, 1'b1, RAMP,  1'b1, 16'h0000, 1'b0);
    vecs[18] = mk(1'b1, 1'b1, TABLE, 1'b1, 16'hCAFE, 1'b0);
    for (int i = 0; i < 19; i++) begin
      en = vecs[i].en; axis.ready = vecs[i].rdy; md = vecs[i].md;
      tick();
      chk_beat($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].el);
    end

    // Mode switch to SQUARE while a beat is stalled
    axis.ready = 1'b0; md = SQUARE;
    tick(); chk_beat("sq.hold0", 1'b1, 16'hCAFE, 1'b0);
    tick(); chk_beat("sq.hold1", 1'b1, 16'hCAFE, 1'b0);
    axis.ready = 1'b1;
    tick(); chk_beat("sq.m0",  1'b1, 16'hCAFE, 1'b0);
    tick(); chk_beat("sq.m1",  1'b1, 16'hC0DE, 1'b1);
    tick(); chk_beat("sq.m0b", 1'b1, 16'hCAFE, 1'b0);

    // Write to the entry being read in the same cycle
    md = TABLE;
    tick(); chk_beat("wr.e0", 1'b1, 16'hCAFE, 1'b0);
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 16'h1234;
    tick(); chk_beat("wr.old", 1'b1, 16'hC0DE, 1'b0);
    wr_en = 1'b0;
    tick(); chk_beat("wr.e2", 1'b1, 16'hBEEF, 1'b0);
    tick(); chk_beat("wr.e3", 1'b1, 16'hB0BA, 1'b1);
    tick(); chk_beat("wr.e0b", 1'b1, 16'hCAFE, 1'b0);
    tick(); chk_beat("wr.new", 1'b1, 16'h1234, 1'b0);

    // Reset with a stalled beat pending
    axis.ready = 1'b0;
    tick(); chk_beat("rst.pend", 1'b1, 16'h1234, 1'b0);
    rst_n = 1'b0;
    tick(); chk_beat("rst.mid", 1'b0, 16'h0000, 1'b0);
`ifdef PATTERN_GEN_CNT_EN
    chk("rst.cnt", beat_cnt, 32'd0);
`endif

    // Randomized traffic against the model, starting from a fresh reset and table
    en = 1'b0; axis.ready = 1'b0;
    model_step(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = 16'($urandom);
      model_step(); tick();
    end
    wr_en = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst_n      = ($urandom_range(0, 199) != 0);
      en         = ($urandom_range(0, 3) != 0);
      axis.ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 11) == 0) md = mode_e'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) tbl_last = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 3))
          0:       step = 16'h0000;
          1:       step = 16'h4000;
          default: step = 16'($urandom);
        endcase
      end
      wr_en   = ($urandom_range(0, 4) == 0);
      wr_addr = 4'($urandom_range(0, 15));
      wr_data = 16'($urandom);
      model_step();
      tick();
      chk("rnd.valid", 32'(axis.valid), 32'(m_valid));
      chk("rnd.data",  32'(axis.data),  32'(m_data));
      chk("rnd.last",  32'(axis.last),  32'(m_last));
`ifdef PATTERN_GEN_CNT_EN
      chk("rnd.cnt", beat_cnt, m_cnt);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
